// File: rtl/spram_access_ctrl_pkg.sv
// Shared definitions for the single-port RAM access controller:
// FSM state encodings and default RAM geometry.
package spram_access_ctrl_pkg;

    localparam int DEF_ADDR_WIDTH = 4;
    localparam int DEF_DATA_WIDTH = 8;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_ISSUE,
        ST_RD_WAIT,
        ST_RSP
    } state_e;

endpackage

// File: rtl/spram_init_seq.sv
// Address sweep counter for the post-reset RAM clear.
// Counts 0..DEPTH-1 while enabled; done flags the last address.
module spram_init_seq #(
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en_i,
    output logic [ADDR_WIDTH-1:0] cnt_o,
    output logic                  done_o
);

    logic [ADDR_WIDTH-1:0] cnt_q;
    logic [ADDR_WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = '0;
        if (en_i) begin
            cnt_d = cnt_q + ADDR_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign done_o = en_i & (cnt_q == '1);

endmodule

// File: rtl/spram_access_ctrl.sv
// Valid/ready request/response front-end for a sync single-port RAM.
// Define SPRAM_CTRL_INIT_EN to sweep INIT_VALUE into the RAM after reset.
module spram_access_ctrl
    import spram_access_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  busy,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout
);

    state_e state_q, state_d;

    logic                  ram_we_q, ram_we_d;
    logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_WIDTH-1:0] ram_din_q, ram_din_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

    logic                  init_act;
    logic                  init_done;
    logic [ADDR_WIDTH-1:0] init_cnt;

`ifdef SPRAM_CTRL_INIT_EN
    localparam state_e RST_STATE = ST_INIT;

    spram_init_seq #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_init_seq (
        .clk   (clk),
        .rst   (rst),
        .en_i  (state_q == ST_INIT),
        .cnt_o (init_cnt),
        .done_o(init_done)
    );

    assign init_act = (state_q == ST_INIT) & ~rst;
`else
    localparam state_e RST_STATE = ST_IDLE;

    assign init_act  = 1'b0;
    assign init_done = 1'b0;
    assign init_cnt  = '0;
`endif

    always_comb begin
        state_d     = state_q;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_din_d   = ram_din_q;
        rsp_rdata_d = rsp_rdata_q;
        unique case (state_q)
            ST_INIT: begin
                if (init_done) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                // RAM drive registers double as the request latch
                if (req_valid) begin
                    state_d    = ST_ISSUE;
                    ram_we_d   = req_we;
                    ram_addr_d = req_addr;
                    ram_din_d  = req_wdata;
                end
            end
            ST_ISSUE: begin
                state_d = ram_we_q ? ST_IDLE : ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                rsp_rdata_d = ram_dout;
                state_d     = ST_RSP;
            end
            ST_RSP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RST_STATE;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_din_q   <= '0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_din_q   <= ram_din_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign req_ready = (state_q == ST_IDLE) & ~rst;
    assign busy      = (state_q != ST_IDLE);
    assign rsp_valid = (state_q == ST_RSP) & ~rst;
    assign rsp_rdata = rsp_rdata_q;

    assign ram_we   = ram_we_q | init_act;
    assign ram_addr = init_act ? init_cnt : ram_addr_q;
    assign ram_din  = init_act ? INIT_VALUE : ram_din_q;

endmodule

// File: tb/tb_spram_access_ctrl.sv
// Scoreboard bench for spram_access_ctrl paired with a behavioural
// sync-read single-port RAM.
module tb_spram_access_ctrl;

    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam logic [DW-1:0] IV = 8'h3C;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [DW-1:0] rsp_rdata;
    logic          busy;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;

    spram_access_ctrl #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .INIT_VALUE(IV)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we   (req_we),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .busy     (busy),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_dout (ram_dout)
    );

    always #5 clk = ~clk;

    // single_port_ram stand-in: sync write, registered read
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int errors  = 0;

    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] exp_q [$];
    int            lat_q [$];
    int            we_q  [$];
    int            wa_q  [$];
    int            wd_q  [$];

    bit            init_phase = 1'b0;
    bit            new_rsp = 1'b1;
    logic [DW-1:0] held = '0;
    int            rdy_mode = 0;
    int            last_hs = 0;

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    // rsp_ready driver: 0 = always ready, 1 = random, 2 = held low
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       rsp_ready = 1'b1;
                1:       rsp_ready = 1'($urandom_range(0, 1));
                default: rsp_ready = 1'b0;
            endcase
        end
    end

    // Monitor: RAM write strobes and response stream
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            lat_q.delete();
            we_q.delete();
            wa_q.delete();
            wd_q.delete();
            new_rsp = 1'b1;
        end else begin
            if (ram_we && !init_phase) begin
                if (we_q.size() == 0) begin
                    chk("we_spurious", 1, 0);
                end else begin
                    chk("we_cycle", cyc, we_q.pop_front() + 1);
                    chk("we_addr", int'(ram_addr), wa_q.pop_front());
                    chk("we_din", int'(ram_din), wd_q.pop_front());
                end
            end
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", 1, 0);
                end else begin
                    if (new_rsp) begin
                        chk("rsp_latency", cyc - lat_q.pop_front(), 3);
                        held    = rsp_rdata;
                        new_rsp = 1'b0;
                    end else begin
                        chk("rsp_stable", int'(rsp_rdata), int'(held));
                    end
                    if (rsp_ready) begin
                        chk("rsp_data", int'(rsp_rdata),
                            int'(exp_q.pop_front()));
                        new_rsp = 1'b1;
                    end
                end
            end
        end
    end

    // Present one request; expectations are recorded at the handshake
    task automatic issue(input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input bit keep);
        bit ok = 1'b0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (req_ready) ok = 1'b1;
        end
        if (!ok) begin
            chk("req_timeout", 0, 1);
        end else begin
            chk("no_req_while_rsp", exp_q.size(), 0);
            last_hs = cyc;
            if (we) begin
                ref_mem[a] = d;
                we_q.push_back(cyc);
                wa_q.push_back(int'(a));
                wd_q.push_back(int'(d));
            end else begin
                exp_q.push_back(ref_mem[a]);
                lat_q.push_back(cyc);
            end
        end
        @(posedge clk);
        #1;
        if (!keep) begin
            req_valid = 1'b0;
            req_we    = 1'($urandom_range(0, 1));
            req_addr  = AW'($urandom);
            req_wdata = DW'($urandom);
        end
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) ok = 1'b1;
        end
        if (!ok) chk("idle_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
`ifdef SPRAM_CTRL_INIT_EN
        int  busy_n = 0;
        bit  done   = 1'b0;
`endif
        @(posedge clk);
        #1;
        rst       = 1'b1;
        req_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
`ifdef SPRAM_CTRL_INIT_EN
        init_phase = 1'b1;
        for (int k = 0; k < DEPTH; k++) ref_mem[k] = IV;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge clk);
            if (busy) begin
                chk("init_addr", int'(ram_addr), busy_n);
                chk("init_din", int'(ram_din), int'(IV));
                chk("init_we", int'(ram_we), 1);
                chk("init_ready", int'(req_ready), 0);
                busy_n++;
            end else begin
                done = 1'b1;
            end
        end
        chk("init_len", busy_n, DEPTH);
        init_phase = 1'b0;
`else
        @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_req_ready", int'(req_ready), 1);
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_ram_we", int'(ram_we), 0);
        chk("rst_ram_addr", int'(ram_addr), 0);
        chk("rst_ram_din", int'(ram_din), 0);
        chk("rst_rsp_rdata", int'(rsp_rdata), 0);
`endif
        @(posedge clk);
        #1;
    endtask

    initial begin
        int h1;
        bit seen;
        for (int k = 0; k < DEPTH; k++) ref_mem[k] = '0;

        do_reset(2);

`ifdef SPRAM_CTRL_INIT_EN
        issue(1'b0, 4'hF, 8'h00, 1'b0);
        wait_idle();
`else
        for (int k = 0; k < DEPTH; k++) begin
            issue(1'b1, AW'(k), DW'($urandom), 1'b0);
        end
        wait_idle();
`endif

        // write then read back
        issue(1'b1, 4'h0, 8'hAA, 1'b0);
        issue(1'b0, 4'h0, 8'h00, 1'b0);
        wait_idle();

        // response held under back-pressure
        rdy_mode = 2;
        issue(1'b1, 4'h1, 8'h55, 1'b0);
        issue(1'b0, 4'h1, 8'h00, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        chk("bp_rsp_seen", int'(seen), 1);
        repeat (4) begin
            @(negedge clk);
            chk("bp_rsp_valid", int'(rsp_valid), 1);
            chk("bp_req_ready", int'(req_ready), 0);
            chk("bp_rdata", int'(rsp_rdata), 8'h55);
        end
        rdy_mode = 0;
        wait_idle();

        // back-to-back reads with req_valid held high
        issue(1'b0, 4'h0, 8'h00, 1'b1);
        h1 = last_hs;
        issue(1'b0, 4'h1, 8'h00, 1'b0);
        chk("b2b_gap", last_hs - h1, 4);
        wait_idle();

        // reset while the read sits in RD_WAIT
        issue(1'b0, 4'h1, 8'h00, 1'b0);
        do_reset(1);
        repeat (4) begin
            @(negedge clk);
            chk("rst_no_rsp", int'(rsp_valid), 0);
`ifndef SPRAM_CTRL_INIT_EN
            chk("rst_no_we", int'(ram_we), 0);
`endif
        end
        @(posedge clk);
        #1;
        issue(1'b0, 4'h1, 8'h00, 1'b0);
        wait_idle();

        // randomized traffic with random back-pressure
        rdy_mode = 1;
        for (int t = 0; t < 300; t++) begin
            issue(1'($urandom_range(0, 1)), AW'($urandom),
                  DW'($urandom), 1'b0);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        rdy_mode = 0;
        wait_idle();
        chk("drain_exp", exp_q.size(), 0);
        chk("drain_we", we_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end

endmodule
